// File: rtl/io_pkg.sv
// Shared definitions for the UART I/O bridge: FSM encodings, io_err bit
// indices and UART frame constants.
// Imported by uart_io_bridge; it has no ports.
package io_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  // io_err bit positions
  localparam int ERR_OVR  = 0;
  localparam int ERR_FRM  = 1;
  localparam int ERR_FST  = 2;
  localparam int ERR_FULL = 3;
  localparam int ERR_W    = 5;

  // 8N1 frame
  localparam int   DATA_BITS = 8;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/io_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a pushed word shows on dout/!empty the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk, rstn (sync, active-low), push/din write side, pop/dout read side,
//        empty/full status.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_io_bridge.sv
// UART responder for the core io ports: io_out bytes -> 8N1 on txd, rxd -> RX FIFO -> io_in.
// Latency: txd start bit the cycle after accept, io_out_rdy back 10 bit times later;
//          an RX byte is visible on io_in the cycle after its stop-bit centre.
// Backpressure: io_out_rdy low while a frame is on the wire; RX bytes arriving to a
//          full FIFO are dropped and flagged as overrun.
// Ports: clk, rstn (sync, active-low); rxd/txd pins; io_in_* (data/vld/rdy) to CPU;
//        io_out_* (data/vld/rdy) from CPU; io_err {0, full, false start, framing, overrun}.
module uart_io_bridge
  import io_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  output logic                 txd,
  output logic [DATA_BITS-1:0] io_in_data,
  output logic                 io_in_vld,
  input  logic                 io_in_rdy,
  input  logic [DATA_BITS-1:0] io_out_data,
  input  logic                 io_out_vld,
  output logic                 io_out_rdy,
  output logic [ERR_W-1:0]     io_err
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  // The IDLE cycle that raises io_out_rdy is the last stop-bit cycle, so a
  // back-to-back byte gets a full-length stop bit with no extra idle gap.
  localparam logic [CW-1:0] STOP_LAST = CW'(CLK_PER_BIT - 2);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state;
  tx_state_t            tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_accept;
  logic                 tx_bit_end;

  assign tx_accept  = io_out_vld && io_out_rdy;
  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == LAST_BIT) tx_next = TX_STOP;
      TX_STOP:  if (tx_cnt == STOP_LAST) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    io_out_rdy = (tx_state == TX_IDLE);
    case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_shift[0];
      default:  txd = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (tx_accept) tx_shift <= io_out_data;
        end
        TX_START: tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: tx_cnt <= tx_cnt + 1'b1;
        default: tx_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t            rx_state;
  rx_state_t            rx_next;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_bit_end;
  logic                 rx_half;
  logic                 rx_push;
  logic                 frm_evt;
  logic                 fst_evt;

  // Two-flop synchroniser; resets to the idle line level so reset never
  // looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= IDLE_LVL;
      rx_s    <= IDLE_LVL;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_half    = (rx_cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (!rx_s) rx_next = RX_START;
      RX_START:     if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_bit_end && rx_bit == LAST_BIT) rx_next = RX_STOP;
      RX_STOP:      if (rx_bit_end) rx_next = rx_s ? RX_IDLE : RX_WAIT_IDLE;
      // Stay here through a break until the line returns high.
      RX_WAIT_IDLE: if (rx_s) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_state == RX_STOP)  && rx_bit_end && rx_s;
    frm_evt = (rx_state == RX_STOP)  && rx_bit_end && !rx_s;
    fst_evt = (rx_state == RX_START) && rx_half    && rx_s;
  end

  // Counter restarts at the start-bit centre, so every later sample lands
  // at a bit centre.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_bit   <= rx_bit + 1'b1;
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: rx_cnt <= rx_cnt + 1'b1;
        default: rx_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic fifo_pop;
  logic fifo_empty;
  logic fifo_full;
  logic ovr_evt;

  assign fifo_pop = io_in_vld && io_in_rdy;
  assign ovr_evt  = rx_push && fifo_full && !fifo_pop;

  io_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (rx_shift),
    .dout  (io_in_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign io_in_vld = !fifo_empty;

  // ---------------------------------------------------------------- errors
  logic err_ovr;
  logic err_frm;
  logic err_fst;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_ovr <= 1'b0;
      err_frm <= 1'b0;
      err_fst <= 1'b0;
    end else begin
      if (ovr_evt) err_ovr <= 1'b1;
      if (frm_evt) err_frm <= 1'b1;
      if (fst_evt) err_fst <= 1'b1;
    end
  end

  always_comb begin
    io_err           = '0;
    io_err[ERR_OVR]  = err_ovr;
    io_err[ERR_FRM]  = err_frm;
    io_err[ERR_FST]  = err_fst;
    io_err[ERR_FULL] = fifo_full;
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Self-checking bench for uart_io_bridge (CLK_PER_BIT=8, FIFO_DEPTH=4).
// Expected TX waveforms are built from the frame bit list; RX expectations come
// from a bounded byte queue plus sticky error flags.
module tb_uart_io_bridge;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd;
  logic       txd;
  logic [7:0] io_in_data;
  logic       io_in_vld;
  logic       io_in_rdy;
  logic [7:0] io_out_data;
  logic       io_out_vld;
  logic       io_out_rdy;
  logic [4:0] io_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         ovr_e, frm_e, fst_e;

  uart_io_bridge #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rxd         (rxd),
    .txd         (txd),
    .io_in_data  (io_in_data),
    .io_in_vld   (io_in_vld),
    .io_in_rdy   (io_in_rdy),
    .io_out_data (io_out_data),
    .io_out_vld  (io_out_vld),
    .io_out_rdy  (io_out_rdy),
    .io_err      (io_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else ovr_e = 1'b1;
  endfunction

  function automatic logic [4:0] exp_err();
    return {1'b0, (q.size() == DEPTH), fst_e, frm_e, ovr_e};
  endfunction

  function automatic void model_reset();
    q.delete();
    ovr_e = 0; frm_e = 0; fst_e = 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send one byte on io_out and check every txd level and io_out_rdy for the
  // whole 10-bit frame. Returns on the cycle rdy is due back.
  task automatic tx_frame(input logic [7:0] d, input string tag);
    logic [9:0] fr;
    int w;
    fr = {1'b1, d, 1'b0};
    w = 0;
    while (!io_out_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rdy_pre"}, io_out_rdy, 1);
    io_out_data = d;
    io_out_vld  = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      io_out_vld = 1'b0;
      chk({tag, "_txd"}, txd, fr[i / CPB]);
      chk({tag, "_rdy"}, io_out_rdy, (i == 10 * CPB - 1));
    end
  endtask

  // Drive a full 8N1 frame on rxd with a chosen stop level.
  task automatic rx_send(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      rxd = fr[i / CPB];
      @(negedge clk);
    end
  endtask

  // Drain the FIFO with random ready, comparing against the model queue.
  task automatic drain_all(input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      chk({tag, "_vld"}, io_in_vld, 1);
      chk({tag, "_data"}, io_in_data, q[0]);
      io_in_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
      if (io_in_rdy) void'(q.pop_front());
    end
    io_in_rdy = 1'b0;
    chk({tag, "_bound"}, q.size(), 0);
    chk({tag, "_vld_empty"}, io_in_vld, 0);
    chk({tag, "_data_empty"}, io_in_data, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] fr;
    int n;

    rstn = 1'b0; rxd = 1'b1; io_in_rdy = 1'b0;
    io_out_vld = 1'b0; io_out_data = '0;
    model_reset();

    // 1. reset state
    idle(3);
    chk("rst_txd", txd, 1);
    chk("rst_rdy", io_out_rdy, 1);
    chk("rst_vld", io_in_vld, 0);
    chk("rst_data", io_in_data, 0);
    chk("rst_err", io_err, 0);
    rstn = 1'b1;
    idle(2);

    // 2. TX 0xA5
    tx_frame(8'hA5, "tx_a5");
    idle(3);

    // 3. RX 0x3C held, then single-cycle pop
    rx_send(8'h3C, 1'b1);
    model_push(8'h3C);
    idle(4);
    chk("rx3c_vld", io_in_vld, 1);
    chk("rx3c_data", io_in_data, 8'h3C);
    idle(10);
    chk("rx3c_hold_vld", io_in_vld, 1);
    chk("rx3c_hold_data", io_in_data, 8'h3C);
    io_in_rdy = 1'b1;
    @(negedge clk);
    io_in_rdy = 1'b0;
    void'(q.pop_front());
    chk("rx3c_pop_vld", io_in_vld, 0);
    chk("rx3c_err", io_err, exp_err());

    // 4. fill and overrun
    for (int k = 1; k <= 5; k++) begin
      rx_send(8'(k), 1'b1);
      model_push(8'(k));
      idle(4);
      chk($sformatf("fill%0d_err", k), io_err, exp_err());
    end
    drain_all("fill_drain");
    chk("fill_err_after", io_err, exp_err());

    // 5. framing error, break, recovery
    rx_send(8'h77, 1'b0);
    rxd = 1'b0;
    idle(40);
    rxd = 1'b1;
    frm_e = 1'b1;
    idle(10);
    chk("frm_err", io_err, exp_err());
    chk("frm_vld", io_in_vld, 0);
    rx_send(8'h55, 1'b1);
    model_push(8'h55);
    idle(4);
    drain_all("frm_recover");

    // 6a. false start
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    fst_e = 1'b1;
    idle(20);
    chk("fst_err", io_err, exp_err());
    chk("fst_vld", io_in_vld, 0);

    // 6b. reset during TX data bits
    b = 8'($urandom);
    fr = {1'b1, b, 1'b0};
    io_out_data = b;
    io_out_vld  = 1'b1;
    @(negedge clk);
    io_out_vld = 1'b0;
    idle(20);
    chk("mid_txd_pre", txd, fr[20 / CPB]);
    rstn = 1'b0;
    @(negedge clk);
    model_reset();
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_rdy", io_out_rdy, 1);
    chk("mid_rst_err", io_err, 0);
    chk("mid_rst_vld", io_in_vld, 0);
    rstn = 1'b1;
    idle(3);

    // Random traffic on both directions at once
    fork
      begin
        for (int k = 0; k < 4; k++) tx_frame(8'($urandom), "rnd_tx");
      end
      begin
        for (int r = 0; r < 3; r++) begin
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            rx_send(b, 1'b1);
            model_push(b);
            idle($urandom_range(0, 3));
          end
          idle(4);
          chk("rnd_rx_err", io_err, exp_err());
          drain_all("rnd_rx_drain");
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
